// File: rtl/switch_led_debouncer.sv
// switch_led_debouncer: synchronised, debounced slide switches driving registered LEDs
// in direct, toggle-latch, blink-gated or inverted mode.
module switch_led_debouncer #(
    parameter int N_CH              = 6,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int BLINK_HALF_PERIOD = 50_000_000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_switch,
    input  logic [1:0]      i_mode,
    output logic [N_CH-1:0] o_led,
    output logic [N_CH-1:0] o_sw_stable,
    output logic [N_CH-1:0] o_sw_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int BW = $clog2(BLINK_HALF_PERIOD);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_PERIOD - 1);

    logic [N_CH-1:0] s1_q, s2_q, stable_q, stable_d, rise_q, tgl_q, led_q, led_d;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [BW-1:0]   blink_q, blink_d;
    logic            phase_q, phase_d;

    // A channel commits only after its synchronised level has differed for a full window.
    always_comb begin
        stable_d = stable_q;
        for (int c = 0; c < N_CH; c++) begin
            cnt_d[c] = '0;
            if (s2_q[c] != stable_q[c]) begin
                cnt_d[c]    = (cnt_q[c] == CNT_LAST) ? '0 : cnt_q[c] + 1'b1;
                stable_d[c] = (cnt_q[c] == CNT_LAST) ? s2_q[c] : stable_q[c];
            end
        end
    end

    always_comb begin
        blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
        phase_d = phase_q ^ (blink_q == BLINK_LAST);
        led_d   = (i_mode == 2'b00) ? stable_q :
                  (i_mode == 2'b01) ? tgl_q :
                  (i_mode == 2'b10) ? (stable_q & {N_CH{phase_q}}) : ~stable_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cnt_q    <= '{default: '0};
            stable_q <= '0;
            rise_q   <= '0;
            tgl_q    <= '0;
            blink_q  <= '0;
            phase_q  <= 1'b0;
            led_q    <= '0;
        end else begin
            s1_q     <= i_switch;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= stable_d & ~stable_q;
            tgl_q    <= tgl_q ^ rise_q;
            blink_q  <= blink_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
        end
    end

    assign o_led       = led_q;
    assign o_sw_stable = stable_q;
    assign o_sw_rise   = rise_q;
endmodule

// File: tb/tb_switch_led_debouncer.sv
// tb_switch_led_debouncer: directed scenarios plus random switch/mode/reset traffic,
// compared every cycle against a history-window reference model.
module tb_switch_led_debouncer;
    localparam int N = 4, DC = 8, H = 4;

    logic       clk = 0, rst = 0;
    logic [3:0] sw = 0;
    logic [1:0] mode = 0;
    logic [3:0] led, stable, rise;
    int checks = 0, errors = 0;

    switch_led_debouncer #(.N_CH(N), .DEBOUNCE_CYCLES(DC), .BLINK_HALF_PERIOD(H)) dut (
        .i_clk(clk), .i_rst(rst), .i_switch(sw), .i_mode(mode),
        .o_led(led), .o_sw_stable(stable), .o_sw_rise(rise)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: hist[k-1] is the switch value sampled on edge k since reset;
    // the synchronised level seen on edge t is the raw value from edge t-2.
    logic [3:0] hist[$];
    int         ed = 0;
    logic [3:0] m_stable = 0, m_rise = 0, m_tgl = 0, m_led = 0;

    function automatic logic [3:0] s2_at(input int t);
        return (t >= 3) ? hist[t-3] : 4'h0;
    endfunction

    initial begin
        logic [3:0] commit, nled, s;
        bit all_diff, phase;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                hist.delete();
                ed = 0;
                m_stable = 0; m_rise = 0; m_tgl = 0; m_led = 0;
            end else begin
                ed++;
                hist.push_back(sw);
                commit = 0;
                for (int c = 0; c < N; c++) begin
                    if (ed >= DC) begin
                        all_diff = 1;
                        for (int t = ed - DC + 1; t <= ed; t++) begin
                            s = s2_at(t);
                            if (s[c] == m_stable[c]) all_diff = 0;
                        end
                        commit[c] = all_diff;
                    end
                end
                phase = (((ed - 1) / H) % 2) == 1;
                case (mode)
                    2'b00:   nled = m_stable;
                    2'b01:   nled = m_tgl;
                    2'b10:   nled = phase ? m_stable : 4'h0;
                    default: nled = ~m_stable;
                endcase
                m_led    = nled;
                m_tgl    = m_tgl ^ m_rise;
                m_rise   = commit & ~m_stable;
                m_stable = m_stable ^ commit;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("model_stable", stable, m_stable);
        chk("model_rise", rise, m_rise);
        chk("model_led", led, m_led);
    end

    initial begin
        int rises;
        #1 rst = 1;
        sw = 4'hF;
        step(2);
        rst = 0;
        for (int k = 1; k <= 9; k++) begin
            step(1);
            chk("t1_stable_wait", stable, 4'h0);
            chk("t1_led_wait", led, 4'h0);
        end
        step(1);
        chk("t1_stable", stable, 4'hF);
        chk("t1_rise", rise, 4'hF);
        step(1);
        chk("t1_rise_end", rise, 4'h0);
        chk("t1_led", led, 4'hF);

        sw = 0; rst = 1; step(1); rst = 0;
        for (int i = 0; i < 30; i++) begin
            sw[0] = ((i / 3) % 2) == 0;
            step(1);
            chk("t2_bounce", stable, 4'h0);
        end
        sw[0] = 1'b1;
        step(9);
        chk("t2_pre_commit", stable, 4'h0);
        step(1);
        chk("t2_stable", stable, 4'h1);
        step(1);
        chk("t2_led", led, 4'h1);

        sw = 0; rst = 1; step(1); rst = 0;
        mode = 2'b01;
        rises = 0;
        for (int p = 0; p < 3; p++) begin
            sw[2] = 1'b1;
            for (int k = 0; k < 12; k++) begin step(1); rises += int'(rise[2]); end
            sw[2] = 1'b0;
            for (int k = 0; k < 12; k++) begin step(1); rises += int'(rise[2]); end
            chk("t3_led", led, (p == 1) ? 4'h0 : 4'h4);
        end
        chk("t3_rise_count", 4'(rises), 4'd3);

        sw = 4'b0011; step(12);
        sw = 4'b0000; step(12);
        sw = 4'b0011; step(12);
        chk("t5_tgl_setup", led, 4'b0100);
        mode = 2'b00; step(1);
        chk("t5_direct", led, 4'b0011);
        mode = 2'b11; step(1);
        chk("t5_inverted", led, 4'b1100);
        mode = 2'b01; step(1);
        chk("t5_toggle", led, 4'b0100);

        mode = 2'b10; sw = 4'b1010; rst = 1; step(1); rst = 0;
        for (int n = 1; n <= 27; n++) begin
            step(1);
            if (n >= 12) chk("t4_blink", led, ((((n - 1) / H) % 2) == 1) ? 4'b1010 : 4'b0000);
        end

        mode = 2'b11; sw = 4'b1011;
        step(7);
        chk("t6_led_before", led, 4'b0101);
        #1 rst = 1;
        #1;
        chk("t6_led_async", led, 4'h0);
        chk("t6_stable_async", stable, 4'h0);
        chk("t6_rise_async", rise, 4'h0);
        #1 rst = 0;
        step(9);
        chk("t6_restart_wait", stable, 4'h0);
        step(1);
        chk("t6_restart", stable, 4'b1011);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) sw = sw ^ (4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) begin
                #1 rst = 1;
                #2 rst = 0;
            end
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
